// File: rtl/ddr2_init_ctrl_if.sv
// ddr2_init_ctrl_if
//   Groups the bring-up controller's status/handshake signals.
//   master : controller side (samples PLL lock / calib_done, drives status)
//   slave  : MCB / system side
//   Signals:
//     mcb_clk_locked  PLL lock, asynchronous to clk
//     calib_done      MCB calibration complete, asynchronous to clk
//     mcb_sys_rst     active-high reset to the MCB
//     ddr2_ready      memory usable
//     init_fail       calibration retries exhausted
//     retry_count     calibration timeouts in the current bring-up
//     state           current FSM state encoding
interface ddr2_init_ctrl_if;
   logic       mcb_clk_locked;
   logic       calib_done;
   logic       mcb_sys_rst;
   logic       ddr2_ready;
   logic       init_fail;
   logic [3:0] retry_count;
   logic [2:0] state;

   modport master (
      input  mcb_clk_locked, calib_done,
      output mcb_sys_rst, ddr2_ready, init_fail, retry_count, state
   );

   modport slave (
      output mcb_clk_locked, calib_done,
      input  mcb_sys_rst, ddr2_ready, init_fail, retry_count, state
   );
endinterface

// File: rtl/ddr2_init_ctrl.sv
// ddr2_init_ctrl
//   DDR2 MCB bring-up sequencer. Waits for a stable PLL lock, holds the MCB
//   in reset, releases it and waits for calibration with a timeout and a
//   bounded number of retries. Loss of lock at any point restarts the whole
//   sequence.
//   Ports:
//     clk    MCB DRP clock, sole clock
//     rst_n  asynchronous active-low reset
//     bus    ddr2_init_ctrl_if.master (lock/calib inputs, status outputs)
module ddr2_init_ctrl #(
   parameter int unsigned LOCK_STABLE_CYCLES = 256,
   parameter int unsigned RST_HOLD_CYCLES    = 64,
   parameter int unsigned CALIB_TIMEOUT      = 1048576,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   ddr2_init_ctrl_if.master bus
);

   localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                     LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AB > CALIB_TIMEOUT) ? MAX_AB : CALIB_TIMEOUT;
   localparam int          CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CALIB_TIMEOUT - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_WAIT_LOCK   = 3'd0,
      S_LOCK_STABLE = 3'd1,
      S_RST_HOLD    = 3'd2,
      S_CALIB       = 3'd3,
      S_READY       = 3'd4,
      S_FAIL        = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       retry_q, retry_d;
   logic             retry_inc;
   logic             lock_q1, lock_s, cal_q1, cal_s;
   logic             lock_loss;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;

   // 2-flop synchronizers for the asynchronous status inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q1 <= 1'b0;
         lock_s  <= 1'b0;
         cal_q1  <= 1'b0;
         cal_s   <= 1'b0;
      end else begin
         lock_q1 <= bus.mcb_clk_locked;
         lock_s  <= lock_q1;
         cal_q1  <= bus.calib_done;
         cal_s   <= cal_q1;
      end
   end

   // Lock loss overrides every other transition outside WAIT_LOCK
   assign lock_loss = !lock_s && (state_q != S_WAIT_LOCK);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_WAIT_LOCK;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      retry_inc = 1'b0;
      if (lock_loss) begin
         state_d = S_WAIT_LOCK;
      end else begin
         case (state_q)
            S_WAIT_LOCK:   if (lock_s) state_d = S_LOCK_STABLE;
            S_LOCK_STABLE: if (cnt_q == LS_LAST) state_d = S_RST_HOLD;
            S_RST_HOLD:    if (cnt_q == RH_LAST) state_d = S_CALIB;
            S_CALIB: begin
               // calibration seen on the timeout cycle still wins
               if (cal_s) begin
                  state_d = S_READY;
               end else if (cnt_q == CAL_LAST) begin
                  if (retry_q < RETRY_MAX && retry_q != 4'hF) begin
                     retry_inc = 1'b1;
                     state_d   = S_RST_HOLD;
                  end else begin
                     state_d = S_FAIL;
                  end
               end
            end
            S_READY:       if (!cal_s) state_d = S_RST_HOLD;
            S_FAIL:        state_d = S_FAIL;
            default:       state_d = S_WAIT_LOCK;
         endcase
      end
   end

   // Output decode from the current state; registered below so the
   // status flags follow state entry by one cycle. A lock-loss transition
   // forces the reset-side values on the same edge as the state change.
   always_comb begin
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      if (!lock_loss) begin
         case (state_q)
            S_CALIB: sys_rst_d = 1'b0;
            S_READY: begin
               sys_rst_d = 1'b0;
               ready_d   = 1'b1;
            end
            S_FAIL:  fail_d = 1'b1;
            default: ;
         endcase
      end
      if (state_d == S_WAIT_LOCK && state_q != S_WAIT_LOCK) retry_d = 4'd0;
      else if (retry_inc)                                   retry_d = retry_q + 4'd1;
      else                                                  retry_d = retry_q;
   end

   // Shared cycle counter: cleared on every state entry, runs only in the
   // timed states
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if (state_q == S_LOCK_STABLE || state_q == S_RST_HOLD || state_q == S_CALIB) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
         retry_q   <= 4'd0;
      end else begin
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
         retry_q   <= retry_d;
      end
   end

   assign bus.mcb_sys_rst = sys_rst_q;
   assign bus.ddr2_ready  = ready_q;
   assign bus.init_fail   = fail_q;
   assign bus.retry_count = retry_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_ddr2_init_ctrl.sv
module tb_ddr2_init_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   ncmp = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   t0 = 0;

   always #5 clk = ~clk;

   ddr2_init_ctrl_if bus_def ();
   ddr2_init_ctrl_if bus_to ();

   // default parameters
   ddr2_init_ctrl u_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));
   // short timeout, two retries
   ddr2_init_ctrl #(.CALIB_TIMEOUT(100), .MAX_RETRIES(2)) u_to (.clk(clk), .rst_n(rst_n), .bus(bus_to));

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus_def.mcb_clk_locked = 1'b0; bus_def.calib_done = 1'b0;
      bus_to.mcb_clk_locked  = 1'b0; bus_to.calib_done  = 1'b0;
      #3 rst_n = 1'b0;
      #2;
      ncmp++; if (bus_def.state !== 3'd0) begin nerr++; $display("FAIL reset_state: got %0d exp 0", bus_def.state); end
      ncmp++; if (bus_def.mcb_sys_rst !== 1'b1) begin nerr++; $display("FAIL reset_sys_rst: got %b exp 1", bus_def.mcb_sys_rst); end
      ncmp++; if (bus_def.ddr2_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready: got %b exp 0", bus_def.ddr2_ready); end
      ncmp++; if (bus_def.init_fail !== 1'b0) begin nerr++; $display("FAIL reset_fail: got %b exp 0", bus_def.init_fail); end
      ncmp++; if (bus_to.retry_count !== 4'd0) begin nerr++; $display("FAIL reset_retry: got %0d exp 0", bus_to.retry_count); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bringup();
      int t_ls = -1, t_rh = -1, t_cal = -1, t_fall = -1, t_rdy = -1, t_st4 = -1;
      do_reset();
      tick();
      bus_def.mcb_clk_locked = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 400 && t_fall < 0; i++) begin
         tick();
         if (t_ls < 0 && bus_def.state == 3'd1) t_ls = cyc - t0;
         if (t_rh < 0 && bus_def.state == 3'd2) t_rh = cyc - t0;
         if (t_cal < 0 && bus_def.state == 3'd3) t_cal = cyc - t0;
         if (t_fall < 0 && bus_def.mcb_sys_rst == 1'b0) t_fall = cyc - t0;
      end
      ncmp++; if (t_ls !== 3) begin nerr++; $display("FAIL bringup_lock_stable_entry: got %0d exp 3", t_ls); end
      ncmp++; if (t_rh !== 259) begin nerr++; $display("FAIL bringup_rst_hold_entry: got %0d exp 259", t_rh); end
      ncmp++; if (t_cal !== 323) begin nerr++; $display("FAIL bringup_calib_entry: got %0d exp 323", t_cal); end
      ncmp++; if (t_fall !== 324) begin nerr++; $display("FAIL bringup_sys_rst_fall: got %0d exp 324", t_fall); end
      for (int i = 0; i < 100; i++) tick();
      bus_def.calib_done = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 10 && t_rdy < 0; i++) begin
         tick();
         if (t_st4 < 0 && bus_def.state == 3'd4) t_st4 = cyc - t0;
         if (t_rdy < 0 && bus_def.ddr2_ready == 1'b1) t_rdy = cyc - t0;
      end
      ncmp++; if (t_st4 !== 3) begin nerr++; $display("FAIL bringup_ready_state: got %0d exp 3", t_st4); end
      ncmp++; if (t_rdy !== 4) begin nerr++; $display("FAIL bringup_ready_rise: got %0d exp 4", t_rdy); end
      ncmp++; if (bus_def.retry_count !== 4'd0) begin nerr++; $display("FAIL bringup_retry: got %0d exp 0", bus_def.retry_count); end
      ncmp++; if (bus_def.mcb_sys_rst !== 1'b0) begin nerr++; $display("FAIL bringup_ready_sys_rst: got %b exp 0", bus_def.mcb_sys_rst); end
   endtask

   task automatic test_ready_drop();
      int t_rh = -1, t_rdy0 = -1, t_rst1 = -1, t_cal = -1, t_fall = -1, t_rdy = -1;
      bus_def.calib_done = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 100 && t_fall < 0; i++) begin
         tick();
         if (t_rh < 0 && bus_def.state == 3'd2) t_rh = cyc - t0;
         if (t_rdy0 < 0 && bus_def.ddr2_ready == 1'b0) t_rdy0 = cyc - t0;
         if (t_rst1 < 0 && bus_def.mcb_sys_rst == 1'b1) t_rst1 = cyc - t0;
         else if (t_rst1 >= 0 && t_fall < 0 && bus_def.mcb_sys_rst == 1'b0) t_fall = cyc - t0;
         if (t_cal < 0 && bus_def.state == 3'd3) t_cal = cyc - t0;
      end
      ncmp++; if (t_rh !== 3) begin nerr++; $display("FAIL drop_rst_hold_entry: got %0d exp 3", t_rh); end
      ncmp++; if (t_rdy0 !== 4) begin nerr++; $display("FAIL drop_ready_fall: got %0d exp 4", t_rdy0); end
      ncmp++; if (t_rst1 !== 4) begin nerr++; $display("FAIL drop_sys_rst_rise: got %0d exp 4", t_rst1); end
      ncmp++; if (t_cal !== 67) begin nerr++; $display("FAIL drop_calib_entry: got %0d exp 67", t_cal); end
      ncmp++; if (t_fall - t_rst1 !== 64) begin nerr++; $display("FAIL drop_sys_rst_width: got %0d exp 64", t_fall - t_rst1); end
      for (int i = 0; i < 5; i++) tick();
      bus_def.calib_done = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 10 && t_rdy < 0; i++) begin
         tick();
         if (bus_def.ddr2_ready == 1'b1) t_rdy = cyc - t0;
      end
      ncmp++; if (t_rdy !== 4) begin nerr++; $display("FAIL drop_ready_again: got %0d exp 4", t_rdy); end
      ncmp++; if (bus_def.retry_count !== 4'd0) begin nerr++; $display("FAIL drop_retry: got %0d exp 0", bus_def.retry_count); end
   endtask

   task automatic test_lock_loss_ready();
      bus_def.mcb_clk_locked = 1'b0;
      tick();
      tick();
      ncmp++; if (bus_def.mcb_sys_rst !== 1'b0) begin nerr++; $display("FAIL lockloss_pre_sys_rst: got %b exp 0", bus_def.mcb_sys_rst); end
      tick();
      ncmp++; if (bus_def.state !== 3'd0) begin nerr++; $display("FAIL lockloss_state: got %0d exp 0", bus_def.state); end
      ncmp++; if (bus_def.mcb_sys_rst !== 1'b1) begin nerr++; $display("FAIL lockloss_sys_rst: got %b exp 1", bus_def.mcb_sys_rst); end
      ncmp++; if (bus_def.ddr2_ready !== 1'b0) begin nerr++; $display("FAIL lockloss_ready: got %b exp 0", bus_def.ddr2_ready); end
   endtask

   task automatic test_lock_glitch();
      int t_ls = -1, t_wl = -1, t_ls2 = -1, t_rh = -1, t_fall = -1;
      bus_def.calib_done = 1'b0;
      tick();
      bus_def.mcb_clk_locked = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 10 && t_ls < 0; i++) begin
         tick();
         if (bus_def.state == 3'd1) t_ls = cyc - t0;
      end
      ncmp++; if (t_ls !== 3) begin nerr++; $display("FAIL glitch_first_entry: got %0d exp 3", t_ls); end
      while (cyc - t0 < 201) tick();
      bus_def.mcb_clk_locked = 1'b0;
      tick();
      bus_def.mcb_clk_locked = 1'b1;
      for (int i = 0; i < 600 && t_fall < 0; i++) begin
         tick();
         if (t_wl < 0 && bus_def.state == 3'd0) t_wl = cyc - t0;
         if (t_wl >= 0 && t_ls2 < 0 && bus_def.state == 3'd1) t_ls2 = cyc - t0;
         if (t_rh < 0 && bus_def.state == 3'd2) t_rh = cyc - t0;
         if (t_fall < 0 && bus_def.mcb_sys_rst == 1'b0) t_fall = cyc - t0;
      end
      ncmp++; if (t_wl !== 204) begin nerr++; $display("FAIL glitch_wait_lock: got %0d exp 204", t_wl); end
      ncmp++; if (t_ls2 !== 205) begin nerr++; $display("FAIL glitch_restart: got %0d exp 205", t_ls2); end
      ncmp++; if (t_rh !== 461) begin nerr++; $display("FAIL glitch_rst_hold: got %0d exp 461", t_rh); end
      ncmp++; if (t_fall !== 526) begin nerr++; $display("FAIL glitch_sys_rst_fall: got %0d exp 526", t_fall); end
   endtask

   task automatic test_timeout();
      int t_r1 = -1, t_r2 = -1, t_fs = -1, t_if = -1;
      do_reset();
      bus_to.calib_done = 1'b0;
      bus_to.mcb_clk_locked = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 900 && t_if < 0; i++) begin
         tick();
         if (t_r1 < 0 && bus_to.retry_count == 4'd1) t_r1 = cyc - t0;
         if (t_r2 < 0 && bus_to.retry_count == 4'd2) t_r2 = cyc - t0;
         if (t_fs < 0 && bus_to.state == 3'd5) t_fs = cyc - t0;
         if (t_if < 0 && bus_to.init_fail == 1'b1) t_if = cyc - t0;
      end
      ncmp++; if (t_r1 !== 423) begin nerr++; $display("FAIL timeout_retry1: got %0d exp 423", t_r1); end
      ncmp++; if (t_r2 !== 587) begin nerr++; $display("FAIL timeout_retry2: got %0d exp 587", t_r2); end
      ncmp++; if (t_fs !== 751) begin nerr++; $display("FAIL timeout_fail_state: got %0d exp 751", t_fs); end
      ncmp++; if (t_if !== 752) begin nerr++; $display("FAIL timeout_init_fail: got %0d exp 752", t_if); end
      for (int i = 0; i < 20; i++) tick();
      ncmp++; if (bus_to.state !== 3'd5) begin nerr++; $display("FAIL timeout_fail_sticky: got %0d exp 5", bus_to.state); end
      ncmp++; if (bus_to.retry_count !== 4'd2) begin nerr++; $display("FAIL timeout_retry_final: got %0d exp 2", bus_to.retry_count); end
      ncmp++; if (bus_to.mcb_sys_rst !== 1'b1) begin nerr++; $display("FAIL timeout_sys_rst: got %b exp 1", bus_to.mcb_sys_rst); end
   endtask

   task automatic test_fail_recover();
      int t_fall = -1;
      bus_to.mcb_clk_locked = 1'b0;
      tick();
      tick();
      ncmp++; if (bus_to.init_fail !== 1'b1) begin nerr++; $display("FAIL recover_fail_held: got %b exp 1", bus_to.init_fail); end
      tick();
      ncmp++; if (bus_to.state !== 3'd0) begin nerr++; $display("FAIL recover_state: got %0d exp 0", bus_to.state); end
      ncmp++; if (bus_to.init_fail !== 1'b0) begin nerr++; $display("FAIL recover_init_fail: got %b exp 0", bus_to.init_fail); end
      ncmp++; if (bus_to.retry_count !== 4'd0) begin nerr++; $display("FAIL recover_retry: got %0d exp 0", bus_to.retry_count); end
      bus_to.mcb_clk_locked = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 400 && t_fall < 0; i++) begin
         tick();
         if (bus_to.mcb_sys_rst == 1'b0) t_fall = cyc - t0;
      end
      ncmp++; if (t_fall !== 324) begin nerr++; $display("FAIL recover_sys_rst_fall: got %0d exp 324", t_fall); end
   endtask

   task automatic test_async_reset();
      int t_fall = -1, t_cal = -1;
      bit hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         tick();
         if (bus_to.state == 3'd3 && bus_to.retry_count == 4'd1) hit = 1'b1;
      end
      ncmp++; if (hit !== 1'b1) begin nerr++; $display("FAIL async_reach_calib: got %b exp 1", hit); end
      #2 rst_n = 1'b0;
      #1;
      ncmp++; if (bus_to.state !== 3'd0) begin nerr++; $display("FAIL async_state: got %0d exp 0", bus_to.state); end
      ncmp++; if (bus_to.mcb_sys_rst !== 1'b1) begin nerr++; $display("FAIL async_sys_rst: got %b exp 1", bus_to.mcb_sys_rst); end
      ncmp++; if (bus_to.retry_count !== 4'd0) begin nerr++; $display("FAIL async_retry: got %0d exp 0", bus_to.retry_count); end
      ncmp++; if (bus_to.init_fail !== 1'b0 || bus_to.ddr2_ready !== 1'b0) begin nerr++; $display("FAIL async_flags: got %b%b exp 00", bus_to.init_fail, bus_to.ddr2_ready); end
      ncmp++; if (bus_def.mcb_sys_rst !== 1'b1) begin nerr++; $display("FAIL async_def_sys_rst: got %b exp 1", bus_def.mcb_sys_rst); end
      tick();
      rst_n = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 400 && t_fall < 0; i++) begin
         tick();
         if (t_cal < 0 && bus_to.state == 3'd3) t_cal = cyc - t0;
         if (bus_def.mcb_sys_rst == 1'b0) t_fall = cyc - t0;
      end
      ncmp++; if (t_fall !== 324) begin nerr++; $display("FAIL restart_sys_rst_fall: got %0d exp 324", t_fall); end
      ncmp++; if (t_cal !== 323) begin nerr++; $display("FAIL restart_calib_entry: got %0d exp 323", t_cal); end
   endtask

   task automatic test_timeout_tie();
      bit hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         tick();
         if (bus_to.state == 3'd3 && bus_to.retry_count == 4'd1) hit = 1'b1;
      end
      ncmp++; if (hit !== 1'b1) begin nerr++; $display("FAIL tie_reach_calib: got %b exp 1", hit); end
      for (int i = 0; i < 97; i++) tick();
      bus_to.calib_done = 1'b1;
      tick();
      tick();
      tick();
      ncmp++; if (bus_to.state !== 3'd4) begin nerr++; $display("FAIL tie_state: got %0d exp 4", bus_to.state); end
      ncmp++; if (bus_to.retry_count !== 4'd1) begin nerr++; $display("FAIL tie_retry: got %0d exp 1", bus_to.retry_count); end
      tick();
      ncmp++; if (bus_to.ddr2_ready !== 1'b1) begin nerr++; $display("FAIL tie_ready: got %b exp 1", bus_to.ddr2_ready); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_bringup();
      test_ready_drop();
      test_lock_loss_ready();
      test_lock_glitch();
      test_timeout();
      test_fail_recover();
      test_async_reset();
      test_timeout_tie();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/ddr2_init_ctrl.md
DDR2_INIT_CTRL -- requirements
Module: ddr2_init_ctrl

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 256: consecutive cycles synchronized lock must stay high before MCB reset release is armed.
REQ-002 Parameter RST_HOLD_CYCLES, default 64: cycles mcb_sys_rst is held asserted per attempt.
REQ-003 Parameter CALIB_TIMEOUT, default 1048576: cycles allowed for calib_done after reset release.
REQ-004 Parameter MAX_RETRIES, default 3: calibration retries before FAIL; range 0..15.
REQ-005 clk  input  1  MCB DRP clock (62.5 MHz); sole clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 mcb_clk_locked  input  1  PLL lock, asynchronous to clk.
REQ-008 calib_done  input  1  MCB calibration complete, asynchronous to clk.
REQ-009 mcb_sys_rst  output  1  active-high reset to MCB.
REQ-010 ddr2_ready  output  1  memory usable.
REQ-011 init_fail  output  1  retries exhausted.
REQ-012 retry_count  output  4  calibration timeouts in current bring-up.
REQ-013 state  output  3  current FSM state encoding.

Function
REQ-014 mcb_clk_locked and calib_done SHALL each pass through a 2-flop synchronizer; all logic uses synchronized versions (lock_s, cal_s).
REQ-015 FSM states and encodings SHALL be: WAIT_LOCK=0, LOCK_STABLE=1, RST_HOLD=2, CALIB=3, READY=4, FAIL=5; codes 6-7 unused, go to WAIT_LOCK next cycle.
REQ-016 One shared counter, width ceil(log2(max(all cycle parameters)+1)), SHALL be cleared on every state entry.
REQ-017 WAIT_LOCK: mcb_sys_rst=1; lock_s=1 -> LOCK_STABLE.
REQ-018 LOCK_STABLE: mcb_sys_rst=1; counter increments; lock_s=0 -> WAIT_LOCK; counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> RST_HOLD.
REQ-019 RST_HOLD: mcb_sys_rst=1; after exactly RST_HOLD_CYCLES cycles in state -> CALIB.
REQ-020 CALIB: mcb_sys_rst=0; cal_s=1 -> READY; counter reaching CALIB_TIMEOUT-1 without cal_s -> if retry_count<MAX_RETRIES, retry_count+1 and -> RST_HOLD, else -> FAIL.
REQ-021 cal_s=1 and timeout in same cycle SHALL resolve to READY.
REQ-022 READY: mcb_sys_rst=0, ddr2_ready=1; cal_s falling -> RST_HOLD with retry_count unchanged.
REQ-023 FAIL: mcb_sys_rst=1, init_fail=1; terminal until rst_n asserted or lock_s falls.
REQ-024 lock_s=0 in any state except WAIT_LOCK SHALL take priority over all other transitions: -> WAIT_LOCK, mcb_sys_rst=1 same cycle as transition registered, retry_count cleared, init_fail cleared.
REQ-025 All outputs SHALL be registered; ddr2_ready and init_fail are high only while in READY/FAIL respectively (asserted first cycle after state entry, via registered decode).
REQ-026 retry_count SHALL saturate, never wrap; cleared only on WAIT_LOCK entry or reset.
REQ-027 Latency lock edge to mcb_sys_rst deassert SHALL be 2 (sync) + 1 + LOCK_STABLE_CYCLES + RST_HOLD_CYCLES + 1 cycles, deterministic.

Reset
REQ-028 rst_n low SHALL immediately force: state=WAIT_LOCK, mcb_sys_rst=1, ddr2_ready=0, init_fail=0, retry_count=0, counter=0, synchronizer flops=0.
REQ-029 rst_n deassertion mid-bring-up SHALL restart the full sequence from WAIT_LOCK; no partial progress retained.

Verification
REQ-030 Lock high at t0, calib_done high 100 cycles after mcb_sys_rst falls, defaults -> mcb_sys_rst falls at cycle 2+1+256+64+1 after lock edge; ddr2_ready rises 3-4 cycles after calib_done; retry_count=0.
REQ-031 Lock pulses low for 1 cycle at count 200 in LOCK_STABLE -> return to WAIT_LOCK, stable count restarts; mcb_sys_rst never deasserted.
REQ-032 CALIB_TIMEOUT=100, MAX_RETRIES=2, calib_done never asserted -> two RST_HOLD re-entries (retry_count 1, 2), then FAIL with init_fail=1, mcb_sys_rst=1, retry_count=2.
REQ-033 In READY, drop calib_done -> ddr2_ready=0, mcb_sys_rst=1 for 64 cycles, then CALIB; restore calib_done -> READY again.
REQ-034 In FAIL, drop lock then raise it -> init_fail=0, retry_count=0, full sequence repeats; rst_n asserted in CALIB -> all outputs at reset values asynchronously, before next clk edge.
REQ-035 calib_done synchronized rise on exact timeout cycle -> READY, retry_count unchanged.
